// File: rtl/bsg_mem_nr1w_sync_init_synth.sv
// Register-array RAM with N synchronous read ports and one bit-masked write port.
// After reset a sequencer writes init_val_p to every entry. ready_o rises once every
// entry has been written. Reads are write-first because the read address is registered
// and the array mux sits after the register. Read ports can optionally hold their last data.
module bsg_mem_nr1w_sync_init_synth #(
  parameter int unsigned        width_p                = 8,
  parameter int unsigned        els_p                  = 8,
  parameter int unsigned        read_ports_p           = 2,
  parameter bit                 read_write_same_addr_p = 1'b0,
  parameter bit                 latch_last_read_p      = 1'b0,
  parameter logic [width_p-1:0] init_val_p             = '0,
  parameter int unsigned        addr_width_lp          = (els_p == 1) ? 1 : $clog2(els_p)
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  output logic                                   ready_o,
  input  logic                                   w_v_i,
  input  logic [width_p-1:0]                     w_mask_i,
  input  logic [addr_width_lp-1:0]               w_addr_i,
  input  logic [width_p-1:0]                     w_data_i,
  input  logic [read_ports_p-1:0]                r_v_i,
  input  logic [read_ports_p*addr_width_lp-1:0]  r_addr_i,
  output logic [read_ports_p*width_p-1:0]        r_data_o
);

  typedef enum logic [1:0] {eReset, eClear, eReady} state_e;

  localparam logic [addr_width_lp-1:0] LastIdx = addr_width_lp'(els_p - 1);

  state_e                     state_q, state_d;
  logic [addr_width_lp-1:0]   clr_cnt_q, clr_cnt_d;
  logic                       clr_we;
  logic                       w_en;
  logic [addr_width_lp-1:0]   w_idx;
  logic                       w_addr_ok;

  logic [width_p-1:0]         mem_q [els_p];

  // State register and clear counter; reset aborts any clear in progress.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= eReset;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Next-state logic. The first cycle after reset release (state_q still eReset) is
  // already a clear cycle, so the sweep takes exactly els_p cycles.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    unique case (state_q)
      eReset, eClear: begin
        clr_we = ~reset_i;
        if (clr_cnt_q == LastIdx) begin
          state_d   = eReady;
          clr_cnt_d = '0;
        end else begin
          state_d   = eClear;
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      eReady:  state_d = eReady;
      default: state_d = eReset;
    endcase
  end

  // Gate with reset_i so no user access slips through in the cycle reset is raised.
  assign ready_o = (state_q == eReady) && !reset_i;

  // Single-entry arrays ignore the address entirely.
  assign w_idx     = (els_p == 1) ? '0 : w_addr_i;
  assign w_addr_ok = (els_p == 1) || (32'(w_addr_i) < els_p);
  assign w_en      = ready_o && w_v_i && w_addr_ok;

  // Array update: clear sweep has priority and ignores the mask.
  always_ff @(posedge clk_i) begin
    if (clr_we) begin
      mem_q[clr_cnt_q] <= init_val_p;
    end else if (w_en) begin
      mem_q[w_idx] <= (mem_q[w_idx] & ~w_mask_i) | (w_data_i & w_mask_i);
    end
  end

  logic [read_ports_p-1:0] r_v_q;

  // Per-port "read was issued last cycle" flags; reads are ignored until ready.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_v_q <= '0;
    end else begin
      r_v_q <= r_v_i & {read_ports_p{ready_o}};
    end
  end

  for (genvar p = 0; p < read_ports_p; p++) begin : g_rd
    logic [addr_width_lp-1:0] r_addr_q;
    logic [addr_width_lp-1:0] r_idx;
    logic [width_p-1:0]       r_mem_data;

    // Registered read address; holds when the port is idle.
    always_ff @(posedge clk_i) begin
      if (r_v_i[p] && ready_o) begin
        r_addr_q <= r_addr_i[p*addr_width_lp +: addr_width_lp];
      end
    end

    assign r_idx      = (els_p == 1) ? '0 : r_addr_q;
    assign r_mem_data = ((els_p == 1) || (32'(r_addr_q) < els_p)) ? mem_q[r_idx] : '0;

    if (latch_last_read_p) begin : g_latch
      logic [width_p-1:0] r_hold_q;

      // Capture what the port presented so it stays stable while idle.
      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          r_hold_q <= '0;
        end else if (r_v_q[p]) begin
          r_hold_q <= r_mem_data;
        end
      end

      assign r_data_o[p*width_p +: width_p] = r_v_q[p] ? r_mem_data : r_hold_q;
    end else begin : g_nolatch
      assign r_data_o[p*width_p +: width_p] = r_mem_data;
    end
  end

`ifndef SYNTHESIS
  initial begin
    $display("bsg_mem_nr1w_sync_init_synth: width_p=%0d els_p=%0d read_ports_p=%0d",
             width_p, els_p, read_ports_p);
  end

  // Usage checks: access before ready, out-of-range addresses, illegal collisions.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (ready_o || !(w_v_i || (|r_v_i)))
        else $warning("access requested while clear in progress; ignored");
      if (ready_o && (els_p > 1)) begin
        assert (!w_v_i || (32'(w_addr_i) < els_p))
          else $warning("write address %0d out of range", w_addr_i);
        for (int p = 0; p < int'(read_ports_p); p++) begin
          assert (!r_v_i[p] || (32'(r_addr_i[p*addr_width_lp +: addr_width_lp]) < els_p))
            else $warning("read port %0d address out of range", p);
          if (!read_write_same_addr_p) begin
            assert (!(r_v_i[p] && w_v_i &&
                      (r_addr_i[p*addr_width_lp +: addr_width_lp] == w_addr_i)))
              else $warning("read port %0d collides with write address", p);
          end
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_bsg_mem_nr1w_sync_init_synth.sv
module tb_bsg_mem_nr1w_sync_init_synth;

  localparam int W  = 8;
  localparam int E  = 6;
  localparam int P  = 2;
  localparam int AW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: write-first, latching read ports.
  logic          reset1;
  logic          ready1;
  logic          w_v;
  logic [W-1:0]  w_mask, w_data;
  logic [AW-1:0] w_addr;
  logic [P-1:0]  r_v;
  logic [P*AW-1:0] r_addr;
  logic [P*W-1:0]  r_data;

  bsg_mem_nr1w_sync_init_synth #(
    .width_p(W), .els_p(E), .read_ports_p(P), .read_write_same_addr_p(1'b1),
    .latch_last_read_p(1'b1), .init_val_p(8'hA5)
  ) u_dut (
    .clk_i(clk), .reset_i(reset1), .ready_o(ready1), .w_v_i(w_v), .w_mask_i(w_mask),
    .w_addr_i(w_addr), .w_data_i(w_data), .r_v_i(r_v), .r_addr_i(r_addr), .r_data_o(r_data)
  );

  // Single-entry, single-bit instance.
  logic       reset2, ready2, w_v2, w_mask2, w_addr2, w_data2, r_addr2, r_data2;
  logic [0:0] r_v2;

  bsg_mem_nr1w_sync_init_synth #(
    .width_p(1), .els_p(1), .read_ports_p(1), .read_write_same_addr_p(1'b0),
    .latch_last_read_p(1'b0), .init_val_p(1'b1)
  ) u_dut1 (
    .clk_i(clk), .reset_i(reset2), .ready_o(ready2), .w_v_i(w_v2), .w_mask_i(w_mask2),
    .w_addr_i(w_addr2), .w_data_i(w_data2), .r_v_i(r_v2), .r_addr_i(r_addr2),
    .r_data_o(r_data2)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int         due;
    int         port;
    logic [7:0] exp;
    string      name;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic          w_v;
    logic [AW-1:0] w_addr;
    logic [7:0]    w_data;
    logic [7:0]    w_mask;
    logic [1:0]    r_v;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [7:0]    e0;
    logic [7:0]    e1;
  } vec_t;
  vec_t vt[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one cycle, then retire scoreboard entries due in the new cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      sb_t e;
      e = sb_q.pop_front();
      check(e.name, 32'(r_data[e.port*W +: W]), 32'(e.exp));
    end
  endtask

  task automatic drive(input logic wv, input logic [AW-1:0] wa, input logic [7:0] wd,
                       input logic [7:0] wm, input logic [1:0] rv,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    w_v    = wv;
    w_addr = wa;
    w_data = wd;
    w_mask = wm;
    r_v    = rv;
    r_addr = {a1, a0};
  endtask

  task automatic expect_rd(input int port, input logic [7:0] exp, input string name);
    sb_t e;
    e.due  = cyc + 1;
    e.port = port;
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
  endtask

  // Count cycles until ready_o rises, bounded.
  task automatic count_clear(output int n);
    n = 0;
    while (!ready1 && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic sweep_init(input string name);
    for (int a = 0; a < E; a++) begin
      drive(1'b0, '0, '0, '0, 2'b11, AW'(a), AW'(E - 1 - a));
      expect_rd(0, 8'hA5, $sformatf("%s_p0_a%0d", name, a));
      expect_rd(1, 8'hA5, $sformatf("%s_p1_a%0d", name, E - 1 - a));
      tick();
    end
    drive(1'b0, '0, '0, '0, 2'b00, '0, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    vt[0]  = '{1'b1, 3'd2, 8'hFF, 8'hFF, 2'b00, 3'd0, 3'd0, 8'hA5, 8'hA5};
    vt[1]  = '{1'b1, 3'd2, 8'h00, 8'h0F, 2'b00, 3'd0, 3'd0, 8'hA5, 8'hA5};
    vt[2]  = '{1'b0, 3'd0, 8'h00, 8'h00, 2'b01, 3'd2, 3'd0, 8'hF0, 8'hA5};
    vt[3]  = '{1'b1, 3'd4, 8'h3C, 8'hFF, 2'b11, 3'd4, 3'd5, 8'h3C, 8'hA5};
    vt[4]  = '{1'b1, 3'd1, 8'h11, 8'hFF, 2'b01, 3'd0, 3'd0, 8'hA5, 8'hA5};
    vt[5]  = '{1'b0, 3'd0, 8'h00, 8'h00, 2'b11, 3'd4, 3'd1, 8'h3C, 8'h11};
    vt[6]  = '{1'b1, 3'd1, 8'h22, 8'hFF, 2'b00, 3'd0, 3'd0, 8'h3C, 8'h11};
    vt[7]  = '{1'b1, 3'd4, 8'h00, 8'hF0, 2'b00, 3'd0, 3'd0, 8'h3C, 8'h11};
    vt[8]  = '{1'b0, 3'd0, 8'h00, 8'h00, 2'b00, 3'd0, 3'd0, 8'h3C, 8'h11};
    vt[9]  = '{1'b0, 3'd0, 8'h00, 8'h00, 2'b00, 3'd0, 3'd0, 8'h3C, 8'h11};
    vt[10] = '{1'b0, 3'd0, 8'h00, 8'h00, 2'b11, 3'd4, 3'd1, 8'h0C, 8'h22};
    vt[11] = '{1'b1, 3'd3, 8'h5A, 8'h3C, 2'b11, 3'd3, 3'd3, 8'h99, 8'h99};
    vt[12] = '{1'b1, 3'd5, 8'hFF, 8'h00, 2'b01, 3'd5, 3'd0, 8'hA5, 8'h99};
    vt[13] = '{1'b0, 3'd0, 8'h00, 8'h00, 2'b00, 3'd0, 3'd0, 8'hA5, 8'h99};

    reset1 = 1'b1;
    reset2 = 1'b1;
    drive(1'b0, '0, '0, '0, 2'b00, '0, '0);
    w_v2 = 1'b0; w_mask2 = 1'b0; w_addr2 = 1'b0; w_data2 = 1'b0;
    r_v2 = 1'b0; r_addr2 = 1'b0;

    repeat (3) tick();
    check("ready_in_reset", 32'(ready1), 32'd0);

    reset1 = 1'b0;
    count_clear(n);
    check("clear_len", n, E);
    sweep_init("init");

    for (int i = 0; i < 14; i++) begin
      drive(vt[i].w_v, vt[i].w_addr, vt[i].w_data, vt[i].w_mask, vt[i].r_v, vt[i].a0,
            vt[i].a1);
      expect_rd(0, vt[i].e0, $sformatf("vec%0d_p0", i));
      expect_rd(1, vt[i].e1, $sformatf("vec%0d_p1", i));
      tick();
    end
    drive(1'b0, '0, '0, '0, 2'b00, '0, '0);
    tick();
    check("sb_drained", sb_q.size(), 0);

    // Abort the clear at cycle 3 of 6 with a one-cycle reset; clear must restart.
    reset1 = 1'b1;
    tick();
    reset1 = 1'b0;
    repeat (3) tick();
    check("ready_mid_clear", 32'(ready1), 32'd0);
    reset1 = 1'b1;
    tick();
    check("ready_abort_reset", 32'(ready1), 32'd0);
    reset1 = 1'b0;
    count_clear(n);
    check("clear_restart_len", n, E);
    sweep_init("restart");
    tick();
    check("sb_drained2", sb_q.size(), 0);

    // Single-entry instance.
    reset2 = 1'b0;
    n = 0;
    while (!ready2 && n < 10) begin
      n++;
      tick();
    end
    check("e1_clear_len", n, 1);
    r_v2 = 1'b1; r_addr2 = 1'b1;
    tick();
    check("e1_init", 32'(r_data2), 32'd1);
    r_v2 = 1'b0; w_v2 = 1'b1; w_addr2 = 1'b1; w_data2 = 1'b0; w_mask2 = 1'b1;
    tick();
    w_v2 = 1'b0; r_v2 = 1'b1; r_addr2 = 1'b0;
    tick();
    check("e1_write0", 32'(r_data2), 32'd0);
    r_v2 = 1'b0; w_v2 = 1'b1; w_addr2 = 1'b0; w_data2 = 1'b1; w_mask2 = 1'b0;
    tick();
    w_v2 = 1'b0; r_v2 = 1'b1; r_addr2 = 1'b1;
    tick();
    check("e1_mask0", 32'(r_data2), 32'd0);
    r_v2 = 1'b0; w_v2 = 1'b1; w_addr2 = 1'b1; w_data2 = 1'b1; w_mask2 = 1'b1;
    tick();
    w_v2 = 1'b0; r_v2 = 1'b1; r_addr2 = 1'b0;
    tick();
    check("e1_write1", 32'(r_data2), 32'd1);

    // Set to 0, then hold a write of 0 through reset and clear; clear must win.
    r_v2 = 1'b0; w_v2 = 1'b1; w_data2 = 1'b0; w_mask2 = 1'b1;
    tick();
    reset2 = 1'b1;
    tick();
    check("e1_ready_reset", 32'(ready2), 32'd0);
    reset2 = 1'b0;
    tick();
    w_v2 = 1'b0;
    check("e1_ready_after", 32'(ready2), 32'd1);
    r_v2 = 1'b1;
    tick();
    check("e1_no_write_not_ready", 32'(r_data2), 32'd1);
    r_v2 = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bsg_mem_nr1w_sync_init_synth.md
Name: bsg_mem_nr1w_sync_init_synth

Overview:
- Synthesizable register-array RAM with N synchronous read ports and one bit-masked write port.
- Adds over the single-port sync RAM:
  - a post-reset hardware clear sequencer with a ready output;
  - selectable same-address read/write forwarding (write-first);
  - per-port last-read latching.
- Sits under bsg_mem_nr1w_sync wrappers for register files and tag arrays that need a known-zero state after reset without software initialization.

Parameters:
- width_p, (none, must be set), data bits per entry; must be >=1.
- els_p, (none, must be set), number of entries; must be >=1.
- read_ports_p, 2, number of independent read ports; must be >=1.
- read_write_same_addr_p, 0:
  - 1 = a read of the address being written in the same cycle returns the post-write (masked-merged) data;
  - 0 = that collision is illegal.
- latch_last_read_p, 0: 1 = each read port holds its last read data while its r_v_i is low.
- init_val_p, 0: value written to every entry during clear (width_p bits).
- addr_width_lp, `BSG_SAFE_CLOG2(els_p), derived; do not override.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset; starts the clear sequence
- ready_o  out  1  1 = clear complete, accesses accepted
- w_v_i  in  1  write valid
- w_mask_i  in  width_p  per-bit write enable; 1 = bit updated
- w_addr_i  in  addr_width_lp  write address
- w_data_i  in  width_p  write data
- r_v_i  in  read_ports_p  per-port read valid
- r_addr_i  in  read_ports_p*addr_width_lp  port p uses bits [p*addr_width_lp +: addr_width_lp]
- r_data_o  out  read_ports_p*width_p  port p uses bits [p*width_p +: width_p]

Behaviour:
- Clocking and reset:
  - Single clock domain; all state changes on posedge clk_i.
  - Reset is synchronous and active-high.
- FSM states:
  - eReset: entered while reset_i=1.
  - eClear: first cycle with reset_i=0 after reset.
  - eReady.
- eClear sequencing:
  - A clear counter starts at 0.
  - Each eClear cycle writes init_val_p to entry[counter], full width, ignoring w_mask_i, then increments the counter.
  - On the cycle that writes entry els_p-1, the FSM moves to eReady.
  - Clear therefore takes exactly els_p cycles.
  - ready_o rises on the cycle after the last clear write.
- ready_o: 0 in eReset and eClear; 1 in eReady.
- Reset asserted mid-clear or in eReady returns the FSM to eReset and the counter to 0. Clear restarts from entry 0 after reset_i falls.
- While ready_o=0:
  - w_v_i and r_v_i are ignored; no user write lands.
  - Simulation assertion fires if either is high.
- Write (eReady, w_v_i=1):
  - mem[w_addr_i] <= (mem & ~w_mask_i) | (w_data_i & w_mask_i) at the clock edge.
  - w_mask_i = 0 is a legal no-op.
- Read latency is 1 cycle:
  - Port p with r_v_i[p]=1 in cycle t presents mem[r_addr] on r_data_o[p] during cycle t+1.
  - The address is registered; the mux follows the register.
- Read with r_v_i[p]=0 in cycle t:
  - latch_last_read_p=0: r_data_o[p] in t+1 is undefined (registered address X'd); the bench must not check it.
  - latch_last_read_p=1: r_data_o[p] holds the last valid read value. The holding register resets to 0 via reset_i.
- The read output never auto-updates from later writes while held.
- Same-cycle read and write of the same address:
  - read_write_same_addr_p=1: the read returns the merged new value.
  - read_write_same_addr_p=0: assertion error; read data undefined.
- Multiple ports reading the same address in the same cycle: legal; all ports return identical data.
- els_p=1: addresses are ignored (treated as 0).
- Address >= els_p (non-power-of-2 els_p):
  - write dropped;
  - read data undefined;
  - assertion fires.
- Simulation-only banner prints width_p, els_p and read_ports_p.

Test Plan:
- width_p=8, els_p=6, init_val_p=8'hA5: reset for 3 cycles, then release -> ready_o=0 for exactly 6 cycles then 1; reading all 6 addresses returns 8'hA5.
- eReady: write addr 2 data 8'hFF mask 8'hFF, then write addr 2 data 8'h00 mask 8'h0F, then read addr 2 -> r_data_o = 8'hF0 one cycle after r_v_i.
- read_write_same_addr_p=1: in one cycle write addr 4 data 8'h3C mask 8'hFF while port 0 reads addr 4 and port 1 reads addr 5 -> next cycle port0 = 8'h3C, port1 = old addr-5 value.
- latch_last_read_p=1: port 1 reads addr 1 (8'h11), then r_v_i low for 4 cycles while addr 1 is rewritten to 8'h22 -> r_data_o[1] stays 8'h11; a new read then returns 8'h22.
- Reset at clear cycle 3 of 6, held 1 cycle -> ready_o stays 0; full 6-cycle clear restarts; entries 0..2 written by the aborted clear still read init_val_p.
- els_p=1, width_p=1: write 1 with arbitrary w_addr_i, read -> 1; w_v_i high while ready_o=0 -> no change, assertion logged.
